// File: rtl/hc4e_prog_loader_if.sv
// hc4e_prog_loader_if
// Byte-stream channel carrying a program image into the hc4e program loader.
//
// Signals:
//   rx_data  - image byte, driven by the source
//   rx_valid - rx_data holds a byte, driven by the source
//   rx_ready - sink can take a byte, driven by the sink
// A byte moves on a rising clock edge where rx_valid and rx_ready are both high.
//
// Modports:
//   master - byte source (testbench or upstream link)
//   slave  - byte sink (the loader)
interface hc4e_prog_loader_if #(
   parameter int unsigned DATA_W = 8
);

   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );

endinterface

// File: rtl/hc4e_prog_loader.sv
// hc4e_prog_loader
// Program-memory stage in front of the hc4e core. A checksummed image arrives
// over a byte stream and is written into a 2**ADDR_W x DATA_W instruction
// memory. The core is held in reset until a load passes its checksum. After
// that the block serves instruction fetches at the core's pc.
//
// Image format: LEN, then N data bytes, then CHK.
//   N = LEN, except that LEN == 0 means N = 2**ADDR_W.
//   CHK must equal (LEN + sum of data bytes) mod 2**DATA_W.
//
// Ports:
//   clk        - system clock, rising edge
//   nReset     - synchronous active-low reset
//   rx         - image byte stream (slave side); rx_ready is low only in run
//   pc         - fetch address from the core's pc_out
//   instr      - fetched instruction, registered, 1-cycle latency; 0 outside run
//   cpu_nReset - core reset, registered; released by a good load
//   busy       - high from the LEN handshake until the CHK handshake
//   load_err   - the last load failed its checksum
module hc4e_prog_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  nReset,
   hc4e_prog_loader_if.slave     rx,
   input  logic [ADDR_W-1:0]     pc,
   output logic [DATA_W-1:0]     instr,
   output logic                  cpu_nReset,
   output logic                  busy,
   output logic                  load_err
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      StLen  = 3'd0,
      StData = 3'd1,
      StSum  = 3'd2,
      StRun  = 3'd3,
      StErr  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic                busy_q, busy_d;
   logic                load_err_q, load_err_d;
   logic                cpu_nreset_q, cpu_nreset_d;
   logic [DATA_W-1:0]   instr_q, instr_d;

   logic [DATA_W-1:0]   mem_q [Depth];

   logic                xfer;
   logic                mem_we;
   logic [ADDR_W:0]     len_n;

   // Ready in every state except run; run is left only through reset.
   assign rx.rx_ready = (state_q != StRun);
   assign xfer        = rx.rx_valid && rx.rx_ready;

   // LEN of zero encodes a full-depth image, hence the extra bit on remaining.
   assign len_n = (rx.rx_data == '0) ? (ADDR_W + 1)'(Depth) : (ADDR_W + 1)'(rx.rx_data);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      sum_d        = sum_q;
      busy_d       = busy_q;
      load_err_d   = load_err_q;
      cpu_nreset_d = cpu_nreset_q;
      mem_we       = 1'b0;

      unique case (state_q)
         // A failed load waits for a new header exactly like a fresh one.
         StLen, StErr: begin
            if (xfer) begin
               remaining_d = len_n;
               addr_d      = '0;
               sum_d       = rx.rx_data;
               busy_d      = 1'b1;
               load_err_d  = 1'b0;
               state_d     = StData;
            end
         end

         StData: begin
            if (xfer) begin
               mem_we      = 1'b1;
               sum_d       = sum_q + rx.rx_data;
               addr_d      = addr_q + ADDR_W'(1);
               remaining_d = remaining_q - (ADDR_W + 1)'(1);
               if (remaining_q == (ADDR_W + 1)'(1)) begin
                  state_d = StSum;
               end
            end
         end

         StSum: begin
            if (xfer) begin
               busy_d = 1'b0;
               if (rx.rx_data == sum_q) begin
                  cpu_nreset_d = 1'b1;
                  state_d      = StRun;
               end else begin
                  load_err_d = 1'b1;
                  state_d    = StErr;
               end
            end
         end

         StRun: begin
            // Stream is ignored; only fetches happen here.
         end

         default: begin
            state_d = StLen;
         end
      endcase

      // Writes happen only in StData and reads only in StRun, so no collision.
      instr_d = (state_q == StRun) ? mem_q[pc] : '0;
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q      <= StLen;
         addr_q       <= '0;
         remaining_q  <= '0;
         sum_q        <= '0;
         busy_q       <= 1'b0;
         load_err_q   <= 1'b0;
         cpu_nreset_q <= 1'b0;
         instr_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         sum_q        <= sum_d;
         busy_q       <= busy_d;
         load_err_q   <= load_err_d;
         cpu_nreset_q <= cpu_nreset_d;
         instr_q      <= instr_d;
      end
   end

   // Memory is not cleared by reset; a write on a reset edge is suppressed.
   always_ff @(posedge clk) begin
      if (mem_we && nReset) begin
         mem_q[addr_q] <= rx.rx_data;
      end
   end

   assign instr      = instr_q;
   assign cpu_nReset = cpu_nreset_q;
   assign busy       = busy_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_hc4e_prog_loader.sv
module tb_hc4e_prog_loader;

   logic       clk;
   logic       nReset;
   logic [7:0] pc;
   logic [7:0] instr;
   logic       cpu_nReset;
   logic       busy;
   logic       load_err;

   hc4e_prog_loader_if #(.DATA_W(8)) rx_if ();

   hc4e_prog_loader #(
      .ADDR_W (8),
      .DATA_W (8)
   ) dut (
      .clk        (clk),
      .nReset     (nReset),
      .rx         (rx_if),
      .pc         (pc),
      .instr      (instr),
      .cpu_nReset (cpu_nReset),
      .busy       (busy),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: expected memory image and image buffer to send.
   logic [7:0] ref_mem [256];
   logic [7:0] img [256];
   int         vectors;
   int         miscompares;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      nReset         = 1'b0;
      rx_if.rx_valid = 1'b0;
      step();
      nReset = 1'b1;
   endtask

   // Sends one byte after 'gap' idle cycles; idle cycles must leave status alone.
   task automatic send(input logic [7:0] b, input int gap, input logic exp_busy);
      for (int g = 0; g < gap; g++) begin
         rx_if.rx_valid = 1'b0;
         rx_if.rx_data  = 8'($urandom);
         step();
         check("gap_busy", 32'(busy), 32'(exp_busy));
         check("gap_cpu", 32'(cpu_nReset), 0);
      end
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      step();
      rx_if.rx_valid = 1'b0;
   endtask

   // Sends LEN, img[0..n-1], chk. Expected result comes from the checksum rule.
   task automatic load(input int n, input logic [7:0] chk, input int gap);
      logic [7:0] lenb;
      int         s;
      logic       good;
      lenb = 8'(n);
      s    = int'(lenb);
      send(lenb, gap, 1'b0);
      check("len_busy", 32'(busy), 1);
      check("len_err", 32'(load_err), 0);
      check("len_rdy", 32'(rx_if.rx_ready), 1);
      for (int i = 0; i < n; i++) begin
         ref_mem[i] = img[i];
         s          = s + int'(img[i]);
         send(img[i], gap, 1'b1);
         if (i == n - 1 || i < 2) begin
            check("data_busy", 32'(busy), 1);
            check("data_instr", 32'(instr), 0);
         end
      end
      good = (chk == 8'(s));
      send(chk, gap, 1'b1);
      check("chk_busy", 32'(busy), 0);
      check("chk_cpu", 32'(cpu_nReset), 32'(good));
      check("chk_err", 32'(load_err), 32'(!good));
      check("chk_rdy", 32'(rx_if.rx_ready), 32'(!good));
      check("chk_instr", 32'(instr), 0);
   endtask

   task automatic fetch(input logic [7:0] p);
      pc = p;
      step();
      check("fetch_instr", 32'(instr), 32'(ref_mem[p]));
      check("fetch_cpu", 32'(cpu_nReset), 1);
      check("fetch_rdy", 32'(rx_if.rx_ready), 0);
   endtask

   initial begin
      int         n;
      int         s;
      logic [7:0] chk;
      vectors        = 0;
      miscompares    = 0;
      nReset         = 1'b0;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;
      pc             = 8'h00;
      step();
      step();
      check("rst_rdy", 32'(rx_if.rx_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_cpu", 32'(cpu_nReset), 0);
      check("rst_err", 32'(load_err), 0);
      check("rst_instr", 32'(instr), 0);
      nReset = 1'b1;

      // 1: good 3-byte load
      img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
      load(3, 8'h9F, 0);
      fetch(8'h01);
      check("t1_pc1", 32'(instr), 32'h34);
      fetch(8'h02);
      check("t1_pc2", 32'(instr), 32'h56);

      // 2: bad checksum, then a good 1-byte load from the error state
      do_reset();
      img[0] = 8'hAA; img[1] = 8'h01;
      load(2, 8'h00, 0);
      check("t2_err", 32'(load_err), 1);
      img[0] = 8'h7F;
      load(1, 8'h80, 0);
      fetch(8'h00);
      check("t2_pc0", 32'(instr), 32'h7F);

      // 3: full-depth image via LEN = 0
      do_reset();
      for (int i = 0; i < 256; i++) img[i] = 8'(i);
      load(256, 8'h80, 0);
      fetch(8'hFF);
      check("t3_pcff", 32'(instr), 32'hFF);
      fetch(8'h00);
      check("t3_pc00", 32'(instr), 32'h00);
      for (int k = 0; k < 4; k++) fetch(8'($urandom));

      // 4: scenario 1 with 3-cycle stalls between bytes
      do_reset();
      img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
      load(3, 8'h9F, 3);
      for (int k = 0; k < 4; k++) fetch(8'(k));

      // 5: reset after two of three data bytes, then a fresh load
      do_reset();
      send(8'h03, 0, 1'b0);
      send(8'hC1, 0, 1'b1);
      ref_mem[0] = 8'hC1;
      send(8'hC2, 0, 1'b1);
      ref_mem[1] = 8'hC2;
      do_reset();
      check("t5_rdy", 32'(rx_if.rx_ready), 1);
      check("t5_busy", 32'(busy), 0);
      check("t5_cpu", 32'(cpu_nReset), 0);
      check("t5_instr", 32'(instr), 0);
      img[0] = 8'h21; img[1] = 8'h43; img[2] = 8'h65;
      load(3, 8'(3 + 8'h21 + 8'h43 + 8'h65), 0);
      for (int k = 0; k < 3; k++) fetch(8'(k));

      // 6: stream activity in run must be ignored
      rx_if.rx_data  = 8'hEE;
      rx_if.rx_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check("t6_rdy", 32'(rx_if.rx_ready), 0);
         check("t6_cpu", 32'(cpu_nReset), 1);
      end
      rx_if.rx_valid = 1'b0;
      for (int k = 0; k < 3; k++) fetch(8'(k));

      // Randomized loads, good or corrupted, with random stalls
      for (int t = 0; t < 12; t++) begin
         if (cpu_nReset) do_reset();
         n = $urandom_range(1, 24);
         s = n;
         for (int i = 0; i < n; i++) begin
            img[i] = 8'($urandom);
            s      = s + int'(img[i]);
         end
         chk = 8'(s);
         if ($urandom_range(0, 1) == 1) chk = chk ^ 8'($urandom_range(1, 255));
         load(n, chk, $urandom_range(0, 2));
         if (chk == 8'(s)) begin
            for (int k = 0; k < 4; k++) fetch(8'($urandom_range(0, 40)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
